dual_grant_sequencer: RTL and testbench

//  Stores sticky requests from 12 sources and drives the pending mask into the combinational dual

---
 rtl/dgs_pkg.sv | 13 +
 rtl/dual_priority_encoder.sv | 29 ++
 rtl/sat_counter.sv | 16 +
 rtl/dual_grant_sequencer.sv | 99 +++++++++
 tb/tb_dual_grant_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dgs_pkg.sv
// Shared types and sizes for the dual grant sequencer and its companion encoder.
package dgs_pkg;
  localparam int N_REQ = 12;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {IDLE, G1, G2} dgs_state_t;
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_vec_t onehot(idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction
endpackage

// File: rtl/dual_priority_encoder.sv
// Combinational encoder: highest and next-highest set index of the request vector.
module dual_priority_encoder
  import dgs_pkg::*;
(
  input  req_vec_t req,
  output idx_t     first,
  output idx_t     second
);
  logic found_first;
  logic found_second;

  always_comb begin
    first        = '0;
    second       = '0;
    found_first  = 1'b0;
    found_second = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (!found_first) begin
          first       = idx_t'(i);
          found_first = 1'b1;
        end else if (!found_second) begin
          second       = idx_t'(i);
          found_second = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping, cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/dual_grant_sequencer.sv
// Sticky request store that serialises encoder first/second picks as valid/ready grants.
// Define DGS_GRANT_CNT_EN to add the saturating grant_cnt output.
//
//   state | meaning
//   IDLE  | no grant in flight; snapshot encoder pair when anything is pending
//   G1    | presenting snap_first
//   G2    | presenting snap_second (only when the snapshot held two requests)
module dual_grant_sequencer
  import dgs_pkg::*;
`ifdef DGS_GRANT_CNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_in,
  output req_vec_t pend_out,
  input  idx_t     enc_first,
  input  idx_t     enc_second,
  output logic     grant_valid,
  output idx_t     grant_idx,
  output logic     grant_last,
  input  logic     grant_ready,
  output logic     busy
`ifdef DGS_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt
`endif
);
  dgs_state_t state, next_state;
  req_vec_t   pend;
  req_vec_t   clr_mask;
  idx_t       snap_first;
  idx_t       snap_second;
  logic       snap_two;
  logic       any;
  logic       two;
  logic       accept;

  assign any      = |pend;
  assign two      = |(pend & (pend - req_vec_t'(1)));
  assign accept   = grant_valid && grant_ready;
  assign clr_mask = accept ? onehot(grant_idx) : '0;
  assign pend_out = pend;
  assign busy     = (state != IDLE);

  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_last  = 1'b0;
    case (state)
      IDLE: if (any) next_state = G1;
      G1: begin
        grant_valid = 1'b1;
        grant_idx   = snap_first;
        grant_last  = !snap_two;
        if (grant_ready) next_state = snap_two ? G2 : IDLE;
      end
      G2: begin
        grant_valid = 1'b1;
        grant_idx   = snap_second;
        grant_last  = 1'b1;
        if (grant_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A new request on the same edge as its grant clears it must survive, so OR in after masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      snap_first  <= '0;
      snap_second <= '0;
      snap_two    <= 1'b0;
    end else begin
      state <= next_state;
      pend  <= (pend & ~clr_mask) | req_in;
      if (state == IDLE && any) begin
        snap_first  <= enc_first;
        snap_second <= enc_second;
        snap_two    <= two;
      end
    end
  end

`ifdef DGS_GRANT_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_grant_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .count (grant_cnt)
  );
`endif
endmodule

// File: tb/tb_dual_grant_sequencer.sv
// Scoreboard bench: stimulus pushes expected grants, a negedge monitor pops them on each handshake.
module tb_dual_grant_sequencer;
  import dgs_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  req_vec_t req_in = '0;
  logic     grant_ready = 1'b0;
  req_vec_t pend_out;
  idx_t     enc_first, enc_second;
  logic     grant_valid, grant_last, busy;
  idx_t     grant_idx;
`ifdef DGS_GRANT_CNT_EN
  logic [15:0] grant_cnt;
  logic [1:0]  cnt2;
  req_vec_t    pend2;
  idx_t        f2, s2, idx2;
  logic        v2, l2, b2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  dual_priority_encoder u_enc (.req(pend_out), .first(enc_first), .second(enc_second));

  dual_grant_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .pend_out(pend_out),
    .enc_first(enc_first), .enc_second(enc_second),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_last(grant_last),
    .grant_ready(grant_ready), .busy(busy)
`ifdef DGS_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

`ifdef DGS_GRANT_CNT_EN
  dual_priority_encoder u_enc2 (.req(pend2), .first(f2), .second(s2));
  dual_grant_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .pend_out(pend2),
    .enc_first(f2), .enc_second(s2),
    .grant_valid(v2), .grant_idx(idx2), .grant_last(l2),
    .grant_ready(grant_ready), .busy(b2), .grant_cnt(cnt2)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && grant_valid && grant_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", {27'd0, grant_last, grant_idx}, 32'hFFFF_FFFF);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("grant_idx_last", {27'd0, grant_last, grant_idx}, {27'd0, e});
      end
    end
  end

  task automatic expect_grant(input int idx, input logic last);
    exp_q.push_back({last, idx_t'(idx)});
  endtask

  // Drives a one-cycle request pulse; returns #1 into cycle 1 (pend just set).
  task automatic pulse(input req_vec_t v);
    @(posedge clk); #1 req_in = v;
    @(posedge clk); #1 req_in = '0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
    check({name, "_drain_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check({name, "_pend_empty"}, pend_out, 0);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_pend", pend_out, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_last", grant_last, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single request, latency and last flag
    grant_ready = 1'b1;
    expect_grant(5, 1'b1);
    pulse(12'h020);
    check("t1_pend_cycle1", pend_out, 12'h020);
    check("t1_no_valid_cycle1", grant_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_cycle2", grant_valid, 1);
    wait_drain("t1", 20);

    // 2: two requests, one snapshot
    expect_grant(11, 1'b0);
    expect_grant(0, 1'b1);
    pulse(12'h801);
    wait_drain("t2", 20);

    // 3: all requests, pairs with one bubble between
    for (int i = 11; i >= 0; i--) expect_grant(i, (i % 2) == 0);
    pulse(12'hFFF);
    for (int k = 2; k <= 19; k++) begin
      @(posedge clk); #1;
      check($sformatf("t3_valid_c%0d", k), grant_valid, (k % 3) != 1);
    end
    wait_drain("t3", 20);
`ifdef DGS_GRANT_CNT_EN
    check("t3_grant_cnt", grant_cnt, 15);
    check("t3_sat_cnt2", cnt2, 3);
`endif

    // 4: backpressure holds the grant stable
    grant_ready = 1'b0;
    expect_grant(9, 1'b0);
    expect_grant(8, 1'b1);
    pulse(12'h300);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", grant_valid, 1);
      check("t4_hold_idx", {grant_last, grant_idx}, {1'b0, 4'd9});
      @(posedge clk); #1;
    end
    grant_ready = 1'b1;
    wait_drain("t4", 20);

    // 5: set wins over clear on the handshake edge
    expect_grant(10, 1'b1);
    expect_grant(10, 1'b1);
    pulse(12'h400);
    @(posedge clk); #1;
    check("t5_g1_valid", grant_valid, 1);
    req_in = 12'h400;
    @(posedge clk); #1 req_in = '0;
    check("t5_still_pending", pend_out, 12'h400);
    wait_drain("t5", 20);

    // 6: reset mid-grant drops everything
    grant_ready = 1'b0;
    pulse(12'h00C);
    @(posedge clk); #1;
    check("t6_g1_idx", grant_idx, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", grant_valid, 0);
    check("t6_rst_idx", grant_idx, 0);
    check("t6_rst_last", grant_last, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pend", pend_out, 0);
`ifdef DGS_GRANT_CNT_EN
    check("t6_rst_cnt", grant_cnt, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    grant_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("t6_no_replay", grant_valid, 0);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
